s_axi_read: RTL and testbench

AXI4-Lite read-channel responder for the sequencer register file; companion to the write-side slave on the same S_AXI port and address map. Accepts one read address at a time and decodes it into bank0 (global control/status) or bank1 (slot table). Fetches the addressed field, zero-extends it to DATA_WIDTH and returns it on the R channel. Exactly one outstanding transaction; no bursts.

---
 rtl/s_axi_read_pkg.sv | 28 ++
 rtl/s_axi_read_if.sv | 25 ++
 rtl/s_axi_read_decode.sv | 73 +++++++
 rtl/s_axi_read.sv | 114 +++++++++++
 tb/tb_s_axi_read.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/s_axi_read_pkg.sv
// Sequencer register-map package: bank selects, bank0 rows, bank1 fields and
// the read-responder state encoding. Shared with the write-side slave.
package s_axi_read_pkg;

  localparam logic [1:0] BANK_SEL_0 = 2'b00;
  localparam logic [1:0] BANK_SEL_1 = 2'b01;

  localparam logic [7:0] B0_ROW_CTRL    = 8'h00;
  localparam logic [7:0] B0_ROW_STATUS  = 8'h01;
  localparam logic [7:0] B0_ROW_CURCNT  = 8'h02;
  localparam logic [7:0] B0_ROW_ENDCNT  = 8'h03;
  localparam logic [7:0] B0_ROW_DMABASE = 8'h04;
  localparam logic [7:0] B0_ROW_DFXCTRL = 8'h05;

  localparam logic [3:0] B1_FLD_SRC_ADDR = 4'd0;
  localparam logic [3:0] B1_FLD_SRC_SIZE = 4'd1;
  localparam logic [3:0] B1_FLD_DES_ADDR = 4'd2;
  localparam logic [3:0] B1_FLD_DES_SIZE = 4'd3;
  localparam logic [3:0] B1_FLD_STATUS   = 4'd4;
  localparam logic [3:0] B1_FLD_PROFILE  = 4'd5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_RESP  = 2'd2
  } state_t;

endpackage

// File: rtl/s_axi_read_if.sv
// AXI4-Lite read channels (AR and R) of the sequencer S_AXI port.
// A beat transfers on a rising edge where both VALID and READY are high; the
// source holds VALID and its payload stable until that edge, READY may change freely.
interface s_axi_read_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] S_AXI_ARADDR;
  logic                  S_AXI_ARVALID;
  logic                  S_AXI_ARREADY;
  logic [DATA_WIDTH-1:0] S_AXI_RDATA;
  logic [1:0]            S_AXI_RRESP;
  logic                  S_AXI_RVALID;
  logic                  S_AXI_RREADY;

  modport slave (
    input  S_AXI_ARADDR, S_AXI_ARVALID, S_AXI_RREADY,
    output S_AXI_ARREADY, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
  );

  modport master (
    output S_AXI_ARADDR, S_AXI_ARVALID, S_AXI_RREADY,
    input  S_AXI_ARREADY, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
  );
endinterface

// File: rtl/s_axi_read_decode.sv
// Combinational address decode: selects one register field and zero-extends
// (or truncates) it to DATA_WIDTH. Unmapped addresses yield zero.
module s_axi_read_decode
  import s_axi_read_pkg::*;
#(
  parameter int GLOB_ADDR_WIDTH      = 32,
  parameter int ADDR_WIDTH           = 16,
  parameter int DATA_WIDTH           = 32,
  parameter int BANK1_INDEX_WIDTH    = 3,
  parameter int BANK1_SRC_ADDR_WIDTH = 32,
  parameter int BANK1_SRC_SIZE_WIDTH = 26,
  parameter int BANK1_DST_ADDR_WIDTH = 32,
  parameter int BANK1_DST_SIZE_WIDTH = 26,
  parameter int BANK1_STATUS_WIDTH   = 2,
  parameter int BANK1_PROFILE_WIDTH  = 32,
  parameter int BANK0_CONTROL_WIDTH  = 4,
  parameter int BANK0_STATUS_WIDTH   = 4,
  parameter int BANK0_CNT_WIDTH      = BANK1_INDEX_WIDTH
) (
  input  logic [ADDR_WIDTH-1:0]           addr,
  input  logic [BANK1_SRC_ADDR_WIDTH-1:0] src_addr,
  input  logic [BANK1_SRC_SIZE_WIDTH-1:0] src_size,
  input  logic [BANK1_DST_ADDR_WIDTH-1:0] des_addr,
  input  logic [BANK1_DST_SIZE_WIDTH-1:0] des_size,
  input  logic [BANK1_STATUS_WIDTH-1:0]   slot_status,
  input  logic [BANK1_PROFILE_WIDTH-1:0]  profile,
  input  logic [BANK0_CONTROL_WIDTH-1:0]  control,
  input  logic [BANK0_STATUS_WIDTH-1:0]   status,
  input  logic [BANK0_CNT_WIDTH-1:0]      cur_cnt,
  input  logic [BANK0_CNT_WIDTH-1:0]      end_cnt,
  input  logic [GLOB_ADDR_WIDTH-1:0]      dma_base_addr,
  input  logic [GLOB_ADDR_WIDTH-1:0]      dfx_ctrl_addr,
  output logic [DATA_WIDTH-1:0]           data
);

  // Fields are widened to 64 bits first so one slice handles both zero
  // extension and truncation to DATA_WIDTH.
  logic [63:0] sel;
  logic        unused_bits;

  always_comb begin
    sel = '0;
    unique case (addr[15:14])
      BANK_SEL_0: begin
        case (addr[13:6])
          B0_ROW_CTRL:    sel = 64'(control);
          B0_ROW_STATUS:  sel = 64'(status);
          B0_ROW_CURCNT:  sel = 64'(cur_cnt);
          B0_ROW_ENDCNT:  sel = 64'(end_cnt);
          B0_ROW_DMABASE: sel = 64'(dma_base_addr);
          B0_ROW_DFXCTRL: sel = 64'(dfx_ctrl_addr);
          default:        sel = '0;
        endcase
      end
      BANK_SEL_1: begin
        case (addr[5:2])
          B1_FLD_SRC_ADDR: sel = 64'(src_addr);
          B1_FLD_SRC_SIZE: sel = 64'(src_size);
          B1_FLD_DES_ADDR: sel = 64'(des_addr);
          B1_FLD_DES_SIZE: sel = 64'(des_size);
          B1_FLD_STATUS:   sel = 64'(slot_status);
          B1_FLD_PROFILE:  sel = 64'(profile);
          default:         sel = '0;
        endcase
      end
      default: sel = '0;
    endcase
  end

  assign data        = sel[DATA_WIDTH-1:0];
  assign unused_bits = &{1'b0, addr[1:0], sel};

endmodule

// File: rtl/s_axi_read.sv
// AXI4-Lite read responder for the sequencer register file: one outstanding
// read, decoded into bank0/bank1 and returned as a zero-extended word.
module s_axi_read
  import s_axi_read_pkg::*;
#(
  parameter int GLOB_ADDR_WIDTH      = 32,
  parameter int ADDR_WIDTH           = 16,
  parameter int DATA_WIDTH           = 32,
  parameter int BANK1_INDEX_WIDTH    = 3,
  parameter int BANK1_SRC_ADDR_WIDTH = 32,
  parameter int BANK1_SRC_SIZE_WIDTH = 26,
  parameter int BANK1_DST_ADDR_WIDTH = 32,
  parameter int BANK1_DST_SIZE_WIDTH = 26,
  parameter int BANK1_STATUS_WIDTH   = 2,
  parameter int BANK1_PROFILE_WIDTH  = 32,
  parameter int BANK0_CONTROL_WIDTH  = 4,
  parameter int BANK0_STATUS_WIDTH   = 4,
  parameter int BANK0_CNT_WIDTH      = BANK1_INDEX_WIDTH
) (
  input  logic                            clk,
  input  logic                            reset,
  s_axi_read_if.slave                     s_axi,
  output logic [BANK1_INDEX_WIDTH-1:0]    ext_bank1_out_index,
  input  logic [BANK1_SRC_ADDR_WIDTH-1:0] ext_bank1_src_addr,
  input  logic [BANK1_SRC_SIZE_WIDTH-1:0] ext_bank1_src_size,
  input  logic [BANK1_DST_ADDR_WIDTH-1:0] ext_bank1_des_addr,
  input  logic [BANK1_DST_SIZE_WIDTH-1:0] ext_bank1_des_size,
  input  logic [BANK1_STATUS_WIDTH-1:0]   ext_bank1_status,
  input  logic [BANK1_PROFILE_WIDTH-1:0]  ext_bank1_profile,
  input  logic [BANK0_CONTROL_WIDTH-1:0]  ext_bank0_control,
  input  logic [BANK0_STATUS_WIDTH-1:0]   ext_bank0_status,
  input  logic [BANK0_CNT_WIDTH-1:0]      ext_bank0_curCnt,
  input  logic [BANK0_CNT_WIDTH-1:0]      ext_bank0_endCnt,
  input  logic [GLOB_ADDR_WIDTH-1:0]      ext_bank0_dmaBaseAddr,
  input  logic [GLOB_ADDR_WIDTH-1:0]      ext_bank0_dfxCtrlAddr,
  output state_t                          dbg_state
);

  state_t                 state_q, state_d;
  logic [ADDR_WIDTH-1:0]  read_addr_q;
  logic [DATA_WIDTH-1:0]  rdata_q;
  logic [DATA_WIDTH-1:0]  dec_data;
  logic                   arready_q, rvalid_q;
  logic                   ar_hs;

  s_axi_read_decode #(
    .GLOB_ADDR_WIDTH(GLOB_ADDR_WIDTH), .ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH),
    .BANK1_INDEX_WIDTH(BANK1_INDEX_WIDTH),
    .BANK1_SRC_ADDR_WIDTH(BANK1_SRC_ADDR_WIDTH), .BANK1_SRC_SIZE_WIDTH(BANK1_SRC_SIZE_WIDTH),
    .BANK1_DST_ADDR_WIDTH(BANK1_DST_ADDR_WIDTH), .BANK1_DST_SIZE_WIDTH(BANK1_DST_SIZE_WIDTH),
    .BANK1_STATUS_WIDTH(BANK1_STATUS_WIDTH), .BANK1_PROFILE_WIDTH(BANK1_PROFILE_WIDTH),
    .BANK0_CONTROL_WIDTH(BANK0_CONTROL_WIDTH), .BANK0_STATUS_WIDTH(BANK0_STATUS_WIDTH),
    .BANK0_CNT_WIDTH(BANK0_CNT_WIDTH)
  ) u_decode (
    .addr          (read_addr_q),
    .src_addr      (ext_bank1_src_addr),
    .src_size      (ext_bank1_src_size),
    .des_addr      (ext_bank1_des_addr),
    .des_size      (ext_bank1_des_size),
    .slot_status   (ext_bank1_status),
    .profile       (ext_bank1_profile),
    .control       (ext_bank0_control),
    .status        (ext_bank0_status),
    .cur_cnt       (ext_bank0_curCnt),
    .end_cnt       (ext_bank0_endCnt),
    .dma_base_addr (ext_bank0_dmaBaseAddr),
    .dfx_ctrl_addr (ext_bank0_dfxCtrlAddr),
    .data          (dec_data)
  );

  always_comb begin
    state_d = state_q;
    ar_hs   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        ar_hs = s_axi.S_AXI_ARVALID && arready_q;
        if (ar_hs) state_d = ST_FETCH;
      end
      ST_FETCH: state_d = ST_RESP;
      ST_RESP:  if (s_axi.S_AXI_RREADY) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // ARREADY/RVALID are registered from the next state so both are low in
  // reset and can never overlap. The slot index is loaded on the AR
  // handshake so the slot fields have settled by the end of ST_FETCH.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q             <= ST_IDLE;
      read_addr_q         <= '0;
      rdata_q             <= '0;
      arready_q           <= 1'b0;
      rvalid_q            <= 1'b0;
      ext_bank1_out_index <= '0;
    end else begin
      state_q   <= state_d;
      arready_q <= (state_d == ST_IDLE);
      rvalid_q  <= (state_d == ST_RESP);
      if (ar_hs) begin
        read_addr_q         <= s_axi.S_AXI_ARADDR;
        ext_bank1_out_index <= s_axi.S_AXI_ARADDR[BANK1_INDEX_WIDTH+5:6];
      end
      if (state_q == ST_FETCH) rdata_q <= dec_data;
    end
  end

  assign s_axi.S_AXI_ARREADY = arready_q;
  assign s_axi.S_AXI_RVALID  = rvalid_q;
  assign s_axi.S_AXI_RDATA   = rdata_q;
  assign s_axi.S_AXI_RRESP   = 2'b00;
  assign dbg_state           = state_q;

endmodule

// File: tb/tb_s_axi_read.sv
// Bench for s_axi_read: directed register-map reads plus randomized reads
// checked against an address-arithmetic reference of the register map.
module tb_s_axi_read;
  import s_axi_read_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b0;

  s_axi_read_if #(.ADDR_WIDTH(16), .DATA_WIDTH(32)) axi ();

  logic [2:0]  ext_bank1_out_index;
  logic [31:0] ext_bank1_src_addr, ext_bank1_des_addr, ext_bank1_profile;
  logic [25:0] ext_bank1_src_size, ext_bank1_des_size;
  logic [1:0]  ext_bank1_status;
  logic [3:0]  b0_control, b0_status;
  logic [2:0]  b0_cur_cnt, b0_end_cnt;
  logic [31:0] b0_dma_base, b0_dfx_ctrl;
  state_t      dbg_state;

  logic [31:0] tab_src_addr [8];
  logic [25:0] tab_src_size [8];
  logic [31:0] tab_des_addr [8];
  logic [25:0] tab_des_size [8];
  logic [1:0]  tab_status   [8];
  logic [31:0] tab_profile  [8];

  // Slot table as seen by the responder: fields follow the requested row.
  assign ext_bank1_src_addr = tab_src_addr[ext_bank1_out_index];
  assign ext_bank1_src_size = tab_src_size[ext_bank1_out_index];
  assign ext_bank1_des_addr = tab_des_addr[ext_bank1_out_index];
  assign ext_bank1_des_size = tab_des_size[ext_bank1_out_index];
  assign ext_bank1_status   = tab_status[ext_bank1_out_index];
  assign ext_bank1_profile  = tab_profile[ext_bank1_out_index];

  s_axi_read dut (
    .clk                   (clk),
    .reset                 (reset),
    .s_axi                 (axi.slave),
    .ext_bank1_out_index   (ext_bank1_out_index),
    .ext_bank1_src_addr    (ext_bank1_src_addr),
    .ext_bank1_src_size    (ext_bank1_src_size),
    .ext_bank1_des_addr    (ext_bank1_des_addr),
    .ext_bank1_des_size    (ext_bank1_des_size),
    .ext_bank1_status      (ext_bank1_status),
    .ext_bank1_profile     (ext_bank1_profile),
    .ext_bank0_control     (b0_control),
    .ext_bank0_status      (b0_status),
    .ext_bank0_curCnt      (b0_cur_cnt),
    .ext_bank0_endCnt      (b0_end_cnt),
    .ext_bank0_dmaBaseAddr (b0_dma_base),
    .ext_bank0_dfxCtrlAddr (b0_dfx_ctrl),
    .dbg_state             (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Reference register map: address fields by division, value from the bench's copy.
  function automatic logic [31:0] ref_read(input logic [15:0] a);
    int unsigned bank = 32'(a) / 16384;
    int unsigned row  = (32'(a) / 64) % 256;
    int unsigned slot = (32'(a) / 64) % 8;
    int unsigned fld  = (32'(a) / 4) % 16;
    logic [31:0] v = 32'h0;
    if (bank == 0) begin
      case (row)
        0: v = 32'(b0_control);
        1: v = 32'(b0_status);
        2: v = 32'(b0_cur_cnt);
        3: v = 32'(b0_end_cnt);
        4: v = b0_dma_base;
        5: v = b0_dfx_ctrl;
        default: v = 32'h0;
      endcase
    end else if (bank == 1) begin
      case (fld)
        0: v = tab_src_addr[slot];
        1: v = 32'(tab_src_size[slot]);
        2: v = tab_des_addr[slot];
        3: v = 32'(tab_des_size[slot]);
        4: v = 32'(tab_status[slot]);
        5: v = tab_profile[slot];
        default: v = 32'h0;
      endcase
    end
    return v;
  endfunction

  task automatic randomize_banks();
    for (int i = 0; i < 8; i++) begin
      tab_src_addr[i] = $urandom;
      tab_src_size[i] = 26'($urandom);
      tab_des_addr[i] = $urandom;
      tab_des_size[i] = 26'($urandom);
      tab_status[i]   = 2'($urandom);
      tab_profile[i]  = $urandom;
    end
    b0_control  = 4'($urandom);
    b0_status   = 4'($urandom);
    b0_cur_cnt  = 3'($urandom);
    b0_end_cnt  = 3'($urandom);
    b0_dma_base = $urandom;
    b0_dfx_ctrl = $urandom;
  endtask

  // Driver: AR handshake and ST_FETCH checks. Called and returns on a negedge.
  task automatic issue(input logic [15:0] a);
    int waited = 0;
    logic [2:0] exp_idx;
    while (axi.S_AXI_ARREADY !== 1'b1 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    check_eq("arready_idle", 64'(axi.S_AXI_ARREADY), 64'd1);
    exp_idx = 3'((32'(a) / 64) % 8);
    axi.S_AXI_ARADDR  = a;
    axi.S_AXI_ARVALID = 1'b1;
    exp_q.push_back(ref_read(a));
    @(negedge clk);
    axi.S_AXI_ARVALID = 1'b0;
    check_eq("fetch_arready", 64'(axi.S_AXI_ARREADY), 64'd0);
    check_eq("fetch_rvalid", 64'(axi.S_AXI_RVALID), 64'd0);
    check_eq("fetch_state", 64'(dbg_state), 64'(ST_FETCH));
    check_eq("fetch_index", 64'(ext_bank1_out_index), 64'(exp_idx));
    @(negedge clk);
    check_eq("resp_rvalid", 64'(axi.S_AXI_RVALID), 64'd1);
    check_eq("resp_arready", 64'(axi.S_AXI_ARREADY), 64'd0);
  endtask

  // Driver: R handshake after `delay` stalled cycles; scoreboard pop.
  task automatic complete(input int delay, input bit bump_status);
    logic [31:0] exp;
    if (exp_q.size() == 0) begin
      check_eq("scoreboard_empty", 64'd1, 64'd0);
      return;
    end
    exp = exp_q.pop_front();
    if (bump_status) b0_status = 4'h7;
    for (int i = 0; i < delay; i++) begin
      check_eq("stall_rvalid", 64'(axi.S_AXI_RVALID), 64'd1);
      check_eq("stall_arready", 64'(axi.S_AXI_ARREADY), 64'd0);
      check_eq("stall_rdata", 64'(axi.S_AXI_RDATA), 64'(exp));
      @(negedge clk);
    end
    axi.S_AXI_RREADY = 1'b1;
    check_eq("rdata", 64'(axi.S_AXI_RDATA), 64'(exp));
    check_eq("rresp", 64'(axi.S_AXI_RRESP), 64'd0);
    check_eq("rvalid_at_hs", 64'(axi.S_AXI_RVALID), 64'd1);
    @(negedge clk);
    axi.S_AXI_RREADY = 1'b0;
    check_eq("post_rvalid", 64'(axi.S_AXI_RVALID), 64'd0);
    check_eq("post_arready", 64'(axi.S_AXI_ARREADY), 64'd1);
  endtask

  initial begin
    logic [15:0] a;
    int unsigned bank;

    axi.S_AXI_ARADDR  = '0;
    axi.S_AXI_ARVALID = 1'b0;
    axi.S_AXI_RREADY  = 1'b0;
    randomize_banks();

    repeat (3) @(negedge clk);
    check_eq("rst_arready", 64'(axi.S_AXI_ARREADY), 64'd0);
    check_eq("rst_rvalid", 64'(axi.S_AXI_RVALID), 64'd0);
    check_eq("rst_rdata", 64'(axi.S_AXI_RDATA), 64'd0);
    check_eq("rst_rresp", 64'(axi.S_AXI_RRESP), 64'd0);
    check_eq("rst_index", 64'(ext_bank1_out_index), 64'd0);
    check_eq("rst_state", 64'(dbg_state), 64'(ST_IDLE));
    reset = 1'b1;
    @(negedge clk);

    // Directed reads from the register map walkthrough.
    b0_control = 4'hA;
    issue(16'h0000);
    complete(0, 1'b0);

    tab_des_addr[2] = 32'h8000_1000;
    issue(16'h4088);
    complete(1, 1'b0);

    tab_src_size[1] = 26'h3FF_FFFF;
    issue(16'h4044);
    complete(0, 1'b0);

    b0_status = 4'h3;
    issue(16'h0040);
    complete(5, 1'b1);

    issue(16'h8000);
    complete(0, 1'b0);
    issue(16'h0180);
    complete(2, 1'b0);
    issue(16'hC0C3);
    complete(0, 1'b0);
    issue(16'h40FB);
    complete(0, 1'b0);

    // Reset in ST_RESP: response is dropped at once.
    issue(16'h0000);
    reset = 1'b0;
    #1;
    check_eq("midrst_rvalid", 64'(axi.S_AXI_RVALID), 64'd0);
    check_eq("midrst_arready", 64'(axi.S_AXI_ARREADY), 64'd0);
    check_eq("midrst_rdata", 64'(axi.S_AXI_RDATA), 64'd0);
    check_eq("midrst_state", 64'(dbg_state), 64'(ST_IDLE));
    void'(exp_q.pop_front());
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    b0_dma_base = 32'h4000_0000;
    issue(16'h0100);
    complete(0, 1'b0);

    // Randomized reads biased towards mapped rows/fields.
    for (int n = 0; n < 60; n++) begin
      randomize_banks();
      a    = 16'($urandom_range(0, 65535));
      bank = $urandom_range(0, 3);
      if (bank == 0) a[13:6] = 8'($urandom_range(0, 7));
      if (bank == 1) a[5:2]  = 4'($urandom_range(0, 7));
      a[15:14] = 2'(bank);
      issue(a);
      complete(int'($urandom_range(0, 3)), 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
